// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// Holds the owner tag type, the address/data width and the default number
// of outstanding reads.
package mem_port_arbiter_pkg;

    localparam int unsigned AW            = 16;
    localparam int unsigned DEPTH_DEFAULT = 4;

    // Encoding is relied on by owner_fifo: stored bit 0 = fetch, 1 = load
    typedef enum logic {
        OWN_F = 1'b0,
        OWN_L = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// owner_fifo: in-order record of who issued each outstanding memory read.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_owner    record a new read and its owner
//   pop                 retire the head entry (memory response arrived)
//   flush               invalidate every fetch-owned entry, head included
//   full, empty         occupancy status
//   head_owner          owner of the head entry
//   head_valid          head entry still wants its response (flush applied)
module owner_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  owner_e push_owner,
    input  logic   pop,
    input  logic   flush,
    output logic   full,
    output logic   empty,
    output owner_e head_owner,
    output logic   head_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] owner_q, owner_d;
    logic             pop_ok, push_ok;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign head_owner = owner_e'(owner_q[rd_ptr_q]);
    // A flush in the pop cycle kills the head response too
    assign head_valid = valid_q[rd_ptr_q] & ~(flush & (head_owner == OWN_F));

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Next-state: flush clear, then pop, then push so a same-cycle push survives
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        owner_d  = owner_q;
        // Owner bit 1 means load, so ANDing keeps only load entries valid
        valid_d  = flush ? (valid_q & owner_q) : valid_q;

        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            owner_d[wr_ptr_q] = (push_owner == OWN_L);
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            owner_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            owner_q  <= owner_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory read port between fetch and load units.
// Grants and response routing are combinational; an owner FIFO remembers the
// order of outstanding reads so in-order responses reach the right unit.
// Ports:
//   clk, rst                               clock, asynchronous active-high reset
//   f_re, f_raddr / f_grant                fetch request / accept
//   f_ready, f_addr, f_data                fetch response
//   l_re, l_raddr / l_grant                load request / accept
//   l_ready, l_addr, l_data                load response
//   f_flush                                drop all outstanding fetch responses
//   mem_re, mem_raddr                      shared memory read port
//   mem_ready, mem_addr_out, mem_data_out  in-order memory response
//   err                                    sticky: response with nothing outstanding
// Build option: MEM_ARB_RR_EN selects round-robin instead of load priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_re,
    input  logic [AW-1:0] f_raddr,
    output logic          f_grant,
    output logic          f_ready,
    output logic [AW-1:0] f_addr,
    output logic [AW-1:0] f_data,
    input  logic          l_re,
    input  logic [AW-1:0] l_raddr,
    output logic          l_grant,
    output logic          l_ready,
    output logic [AW-1:0] l_addr,
    output logic [AW-1:0] l_data,
    input  logic          f_flush,
    output logic          mem_re,
    output logic [AW-1:0] mem_raddr,
    input  logic          mem_ready,
    input  logic [AW-1:0] mem_addr_out,
    input  logic [AW-1:0] mem_data_out,
    output logic          err
);

    logic   full, empty, head_valid;
    owner_e head_owner, push_owner;
    logic   pop, can_grant, l_wins;
    logic   err_q, err_d;

    assign pop        = mem_ready & ~empty;
    // A full FIFO can still accept when the head leaves this cycle
    assign can_grant  = ~full | pop;
    assign push_owner = l_grant ? OWN_L : OWN_F;

`ifdef MEM_ARB_RR_EN
    logic l_next_q, l_next_d;

    // Pointer flips toward the unit that did not win the latest grant
    always_comb begin
        l_next_d = l_next_q;
        if (f_grant) begin
            l_next_d = 1'b1;
        end else if (l_grant) begin
            l_next_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_next_q <= 1'b0;
        end else begin
            l_next_q <= l_next_d;
        end
    end

    assign l_wins = l_next_q;
`else
    assign l_wins = 1'b1;
`endif

    // Arbitration, memory request and response routing
    always_comb begin
        f_grant   = 1'b0;
        l_grant   = 1'b0;
        mem_raddr = '0;
        f_ready   = 1'b0;
        f_addr    = '0;
        f_data    = '0;
        l_ready   = 1'b0;
        l_addr    = '0;
        l_data    = '0;

        if (!rst && can_grant) begin
            if (l_re && (l_wins || !f_re)) begin
                l_grant = 1'b1;
            end else if (f_re) begin
                f_grant = 1'b1;
            end
        end

        if (l_grant) begin
            mem_raddr = l_raddr;
        end else if (f_grant) begin
            mem_raddr = f_raddr;
        end

        if (pop && head_valid) begin
            if (head_owner == OWN_F) begin
                f_ready = 1'b1;
                f_addr  = mem_addr_out;
                f_data  = mem_data_out;
            end else begin
                l_ready = 1'b1;
                l_addr  = mem_addr_out;
                l_data  = mem_data_out;
            end
        end
    end

    assign mem_re = f_grant | l_grant;

    // Sticky error on a response nobody asked for
    always_comb begin
        err_d = err_q | (mem_ready & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

    owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (mem_re),
        .push_owner (push_owner),
        .pop        (pop),
        .flush      (f_flush),
        .full       (full),
        .empty      (empty),
        .head_owner (head_owner),
        .head_valid (head_valid)
    );

endmodule
